// File: rtl/nand_pkg.sv
// nand_pkg: shared constants, state encoding and helpers
// for the NAND page-read engine.
package nand_pkg;

    localparam logic [7:0] NAND_CMD_READ1 = 8'h00;
    localparam logic [7:0] NAND_CMD_READ2 = 8'h30;

    localparam int NAND_DEF_PAGE_BYTES  = 8192;
    localparam int NAND_DEF_SPARE_BYTES = 448;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_ADDR,
        ST_CMD2,
        ST_WAIT_WB,
        ST_WAIT_RB,
        ST_READ,
        ST_DONE
    } nand_state_e;

    // Address cycle byte: two zero column bytes, then the row LSB first.
    function automatic logic [7:0] nand_addr_byte(
        input logic [2:0]  idx,
        input logic [23:0] row
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd2:    b = row[7:0];
            3'd3:    b = row[15:8];
            3'd4:    b = row[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nand_strobe_gen.sv
// nand_strobe_gen: one active-low strobe of T_LOW low clocks then
// T_HIGH high clocks; go on the end clock chains strobes back to back.
module nand_strobe_gen #(
    parameter int T_LOW  = 2,
    parameter int T_HIGH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic strobe_n,
    output logic capture,
    output logic end_pulse
);

    localparam int CW = $clog2(T_LOW + T_HIGH);
    localparam logic [CW-1:0] LOW_LAST = CW'(T_LOW - 1);
    localparam logic [CW-1:0] LAST     = CW'(T_LOW + T_HIGH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic          strobe_n_q, strobe_n_d;
    logic          capture_q, capture_d;
    logic          end_q, end_d;

    // Next phase position; outputs are decoded from the next count so they stay registered.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (go) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        strobe_n_d = !(active_d && (cnt_d <= LOW_LAST));
        capture_d  = active_d && (cnt_d == LOW_LAST);
        end_d      = active_d && (cnt_d == LAST);
    end

    // Phase counter and strobe output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            active_q   <= 1'b0;
            strobe_n_q <= 1'b1;
            capture_q  <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            strobe_n_q <= strobe_n_d;
            capture_q  <= capture_d;
            end_q      <= end_d;
        end
    end

    assign strobe_n  = strobe_n_q;
    assign capture   = capture_q;
    assign end_pulse = end_q;

endmodule

// File: rtl/flash_page_read_engine.sv
// flash_page_read_engine: issues 00h / 5 addr / 30h, waits tWB and R/B#,
// then strobes RE# across the full page plus spare area.
module flash_page_read_engine
    import nand_pkg::*;
#(
    parameter int PAGE_BYTES  = NAND_DEF_PAGE_BYTES,
    parameter int SPARE_BYTES = NAND_DEF_SPARE_BYTES,
    parameter int T_LOW       = 2,
    parameter int T_HIGH      = 2,
    parameter int T_WB        = 4,
    parameter int RB_TIMEOUT  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] read_addr_row,
    output logic        busy,
    output logic        done,
    output logic        rb_timeout,
    output logic [7:0]  read_data,
    output logic        read_data_valid,
    output logic [13:0] read_data_cnt,
    output logic        nand_ce_n,
    output logic        nand_cle,
    output logic        nand_ale,
    output logic        nand_we_n,
    output logic        nand_re_n,
    output logic [7:0]  nand_dq_out,
    output logic        nand_dq_oe,
    input  logic [7:0]  nand_dq_in,
    input  logic        nand_rb_n
);

    localparam int WMAX = (RB_TIMEOUT > T_WB) ? RB_TIMEOUT : T_WB;
    localparam int WCW  = $clog2(WMAX + 1);
    localparam logic [WCW-1:0] WB_LAST   = WCW'(T_WB - 1);
    localparam logic [WCW-1:0] TO_LAST   = WCW'(RB_TIMEOUT - 1);
    localparam logic [13:0]    LAST_BYTE = 14'(PAGE_BYTES + SPARE_BYTES - 1);

    nand_state_e    state_q, state_d;
    logic [23:0]    row_q, row_d;
    logic [2:0]     bus_idx_q, bus_idx_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [13:0]    byte_cnt_q, byte_cnt_d;
    logic           rb_sync_q, rb_sync_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rb_timeout_q, rb_timeout_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic [13:0]    rd_cnt_q, rd_cnt_d;
    logic           ce_n_q, ce_n_d;
    logic           cle_q, cle_d;
    logic           ale_q, ale_d;
    logic [7:0]     dq_out_q, dq_out_d;
    logic           dq_oe_q, dq_oe_d;
    logic           we_sel_q, we_sel_d;
    logic           re_sel_q, re_sel_d;

    logic st_go;
    logic st_strobe_n;
    logic st_capture;
    logic st_end;

    nand_strobe_gen #(
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH)
    ) u_strobe (
        .clk       (clk),
        .rst       (rst),
        .go        (st_go),
        .strobe_n  (st_strobe_n),
        .capture   (st_capture),
        .end_pulse (st_end)
    );

    // Sequencer next state and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        bus_idx_d    = bus_idx_q;
        wait_cnt_d   = wait_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rb_timeout_d = rb_timeout_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        rd_cnt_d     = rd_cnt_q;
        ce_n_d       = ce_n_q;
        cle_d        = cle_q;
        ale_d        = ale_q;
        dq_out_d     = dq_out_q;
        dq_oe_d      = dq_oe_q;
        we_sel_d     = we_sel_q;
        re_sel_d     = re_sel_q;
        st_go        = 1'b0;
        // R/B# is only looked at while waiting for ready.
        rb_sync_d    = (state_q == ST_WAIT_RB) ? nand_rb_n : 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_CMD1;
                    row_d        = read_addr_row;
                    rb_timeout_d = 1'b0;
                    busy_d       = 1'b1;
                    ce_n_d       = 1'b0;
                    cle_d        = 1'b1;
                    dq_oe_d      = 1'b1;
                    dq_out_d     = NAND_CMD_READ1;
                    we_sel_d     = 1'b1;
                    st_go        = 1'b1;
                end
            end
            ST_CMD1: begin
                if (st_end) begin
                    state_d   = ST_ADDR;
                    cle_d     = 1'b0;
                    ale_d     = 1'b1;
                    bus_idx_d = 3'd0;
                    dq_out_d  = nand_addr_byte(3'd0, row_q);
                    st_go     = 1'b1;
                end
            end
            ST_ADDR: begin
                if (st_end) begin
                    st_go = 1'b1;
                    if (bus_idx_q == 3'd4) begin
                        state_d  = ST_CMD2;
                        ale_d    = 1'b0;
                        cle_d    = 1'b1;
                        dq_out_d = NAND_CMD_READ2;
                    end else begin
                        bus_idx_d = bus_idx_q + 3'd1;
                        dq_out_d  = nand_addr_byte(bus_idx_q + 3'd1, row_q);
                    end
                end
            end
            ST_CMD2: begin
                if (st_end) begin
                    state_d    = ST_WAIT_WB;
                    cle_d      = 1'b0;
                    dq_oe_d    = 1'b0;
                    dq_out_d   = 8'h00;
                    we_sel_d   = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT_WB: begin
                if (wait_cnt_q == WB_LAST) begin
                    state_d    = ST_WAIT_RB;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_WAIT_RB: begin
                if (rb_sync_q) begin
                    state_d    = ST_READ;
                    re_sel_d   = 1'b1;
                    byte_cnt_d = '0;
                    st_go      = 1'b1;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d      = ST_DONE;
                    rb_timeout_d = 1'b1;
                    done_d       = 1'b1;
                    ce_n_d       = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (st_capture) begin
                    rd_data_d  = nand_dq_in;
                    rd_valid_d = 1'b1;
                    rd_cnt_d   = byte_cnt_q;
                end
                if (st_end) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        ce_n_d   = 1'b1;
                        re_sel_d = 1'b0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 14'd1;
                        st_go      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            bus_idx_q    <= '0;
            wait_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            rb_sync_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rb_timeout_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_cnt_q     <= '0;
            ce_n_q       <= 1'b1;
            cle_q        <= 1'b0;
            ale_q        <= 1'b0;
            dq_out_q     <= '0;
            dq_oe_q      <= 1'b0;
            we_sel_q     <= 1'b0;
            re_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            bus_idx_q    <= bus_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rb_sync_q    <= rb_sync_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rb_timeout_q <= rb_timeout_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_cnt_q     <= rd_cnt_d;
            ce_n_q       <= ce_n_d;
            cle_q        <= cle_d;
            ale_q        <= ale_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            we_sel_q     <= we_sel_d;
            re_sel_q     <= re_sel_d;
        end
    end

    // Select flip only while the strobe is high, so the OR cannot glitch low.
    assign nand_we_n       = st_strobe_n | ~we_sel_q;
    assign nand_re_n       = st_strobe_n | ~re_sel_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign rb_timeout      = rb_timeout_q;
    assign read_data       = rd_data_q;
    assign read_data_valid = rd_valid_q;
    assign read_data_cnt   = rd_cnt_q;
    assign nand_ce_n       = ce_n_q;
    assign nand_cle        = cle_q;
    assign nand_ale        = ale_q;
    assign nand_dq_out     = dq_out_q;
    assign nand_dq_oe      = dq_oe_q;

endmodule

// File: tb/tb_flash_page_read_engine.sv
// tb_flash_page_read_engine: directed bench for the NAND page-read engine,
// one default-timing instance and one fast, small-page instance.
module tb_flash_page_read_engine;

    logic        clk;
    logic        rst    [2];
    logic        start  [2];
    logic [23:0] row    [2];
    logic        busy   [2];
    logic        done   [2];
    logic        rbto   [2];
    logic [7:0]  rdata  [2];
    logic        rvalid [2];
    logic [13:0] rcnt   [2];
    logic        ce_n   [2];
    logic        cle    [2];
    logic        ale    [2];
    logic        we_n   [2];
    logic        re_n   [2];
    logic [7:0]  dq_out [2];
    logic        dq_oe  [2];
    logic [7:0]  dq_in  [2];
    logic        rb_n   [2];

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] RST_OUTS = {26'h0, 5'b10011, 9'h0};

    flash_page_read_engine u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .read_addr_row(row[0]),
        .busy(busy[0]), .done(done[0]), .rb_timeout(rbto[0]),
        .read_data(rdata[0]), .read_data_valid(rvalid[0]),
        .read_data_cnt(rcnt[0]), .nand_ce_n(ce_n[0]), .nand_cle(cle[0]),
        .nand_ale(ale[0]), .nand_we_n(we_n[0]), .nand_re_n(re_n[0]),
        .nand_dq_out(dq_out[0]), .nand_dq_oe(dq_oe[0]),
        .nand_dq_in(dq_in[0]), .nand_rb_n(rb_n[0])
    );

    flash_page_read_engine #(
        .PAGE_BYTES(16), .SPARE_BYTES(4), .T_LOW(1), .T_HIGH(1),
        .T_WB(4), .RB_TIMEOUT(100)
    ) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .read_addr_row(row[1]),
        .busy(busy[1]), .done(done[1]), .rb_timeout(rbto[1]),
        .read_data(rdata[1]), .read_data_valid(rvalid[1]),
        .read_data_cnt(rcnt[1]), .nand_ce_n(ce_n[1]), .nand_cle(cle[1]),
        .nand_ale(ale[1]), .nand_we_n(we_n[1]), .nand_re_n(re_n[1]),
        .nand_dq_out(dq_out[1]), .nand_dq_oe(dq_oe[1]),
        .nand_dq_in(dq_in[1]), .nand_rb_n(rb_n[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // NAND model and bus observer, run on the falling edge.
    int          cyc = 0;
    int          vcount  [2] = '{0, 0};
    int          vbad    [2] = '{0, 0};
    int          gapbad  [2] = '{0, 0};
    int          dcount  [2] = '{0, 0};
    int          exp_idx [2] = '{0, 0};
    int          last_v  [2] = '{0, 0};
    int          ale_n   [2] = '{0, 0};
    int          cle_n   [2] = '{0, 0};
    int          re_rise [2] = '{0, 0};
    logic [39:0] ale_log [2] = '{40'h0, 40'h0};
    logic [15:0] cle_log [2] = '{16'h0, 16'h0};
    logic        we_prev [2] = '{1'b1, 1'b1};
    logic        re_prev [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rvalid[i] === 1'b1) begin
                vcount[i]++;
                if (rcnt[i] !== 14'(exp_idx[i]) || rdata[i] !== 8'(exp_idx[i]))
                    vbad[i]++;
                if (exp_idx[i] > 0 && (cyc - last_v[i]) != ((i == 0) ? 4 : 2))
                    gapbad[i]++;
                last_v[i] = cyc;
                exp_idx[i]++;
            end
            if (done[i] === 1'b1) dcount[i]++;
            if (we_n[i] === 1'b1 && we_prev[i] === 1'b0) begin
                if (cle[i] === 1'b1) begin
                    cle_log[i] = {cle_log[i][7:0], dq_out[i]};
                    cle_n[i]++;
                end
                if (ale[i] === 1'b1) begin
                    ale_log[i] = {ale_log[i][31:0], dq_out[i]};
                    ale_n[i]++;
                end
            end
            if (re_n[i] === 1'b1 && re_prev[i] === 1'b0) re_rise[i]++;
            if (ce_n[i] === 1'b1) begin
                exp_idx[i] = 0;
                re_rise[i] = 0;
                ale_n[i]   = 0;
                cle_n[i]   = 0;
                ale_log[i] = '0;
                cle_log[i] = '0;
            end
            we_prev[i] = we_n[i];
            re_prev[i] = re_n[i];
            dq_in[i]   = 8'(re_rise[i]);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] outs(input int i);
        return {busy[i], done[i], rbto[i], rdata[i], rvalid[i], rcnt[i],
                ce_n[i], cle[i], ale[i], we_n[i], re_n[i], dq_out[i], dq_oe[i]};
    endfunction

    initial begin
        int n;
        int v0;
        int d0;
        int b0;

        for (int i = 0; i < 2; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
            row[i]   = '0;
            rb_n[i]  = 1'b1;
        end
        step(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();
        check("reset_outs0", outs(0), RST_OUTS);
        check("reset_outs1", outs(1), RST_OUTS);

        // Full default read, row 123456h, busy for 50 clocks.
        row[0] = 24'h123456;
        v0 = vcount[0];
        d0 = dcount[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("cmd1_pins", {busy[0], ce_n[0], cle[0], we_n[0], dq_oe[0]},
              5'b10101);
        n = 0;
        while (dq_oe[0] === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check("cmd_len", n, 28);
        rb_n[0] = 1'b0;
        check("cle_bytes", cle_log[0], 16'h0030);
        check("ale_bytes", ale_log[0], 40'h0000563412);
        check("bus_cycles", {cle_n[0], ale_n[0]}, {32'd2, 32'd5});
        step(50);
        check("no_read_busy", {re_n[0], vcount[0] - v0}, {1'b1, 32'd0});
        rb_n[0] = 1'b1;
        n = 0;
        while (vcount[0] - v0 < 200 && n < 2000) begin
            n++;
            step();
        end
        check("reach_200", vcount[0] - v0 >= 200, 1'b1);
        row[0] = 24'hABCDEF;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n = 0;
        while (dcount[0] == d0 && n < 40000) begin
            n++;
            step();
        end
        check("done_once", dcount[0] - d0, 1);
        check("byte_count", vcount[0] - v0, 8640);
        check("byte_values", vbad[0], 0);
        check("valid_gap4", gapbad[0], 0);
        check("done_pins", {busy[0], ce_n[0], rbto[0]}, 3'b110);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("start_at_done", busy[0], 1'b0);
        step(3);
        check("idle_after", {busy[0], ce_n[0], dcount[0] - d0}, {2'b01, 32'd1});

        // R/B# stuck low: timeout after 20000 wait clocks.
        rb_n[0] = 1'b0;
        v0 = vcount[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n = 1;
        while (done[0] !== 1'b1 && n < 25000) begin
            n++;
            step();
        end
        check("timeout_len", n, 20033);
        check("timeout_pins", {rbto[0], ce_n[0], busy[0]}, 3'b111);
        check("timeout_nodata", vcount[0] - v0, 0);
        step(4);
        check("timeout_sticky", {rbto[0], busy[0]}, 2'b10);

        // Reset in the middle of READ, then a fresh read.
        rb_n[0] = 1'b1;
        row[0] = 24'h000777;
        v0 = vcount[0];
        b0 = vbad[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("timeout_clear", rbto[0], 1'b0);
        n = 0;
        while (vcount[0] - v0 < 100 && n < 2000) begin
            n++;
            step();
        end
        check("reach_100", rcnt[0], 14'd99);
        rst[0] = 1'b1;
        step();
        check("midrst_outs", outs(0), RST_OUTS);
        rst[0] = 1'b0;
        step();
        v0 = vcount[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n = 0;
        while (vcount[0] - v0 < 5 && n < 500) begin
            n++;
            step();
        end
        check("fresh_cnt", {rcnt[0], rdata[0]}, {14'd4, 8'h04});
        check("fresh_values", vbad[0] - b0, 0);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;

        // Fast timing, R/B# already high during WAIT_WB.
        row[1] = 24'h00ABCD;
        v0 = vcount[1];
        d0 = dcount[1];
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        n = 0;
        while (dq_oe[1] === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check("fast_cmd_len", n, 14);
        check("fast_ale", ale_log[1], 40'h0000CDAB00);
        n = 15;
        while (re_n[1] === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check("fast_read_entry", n, 21);
        n = 0;
        while (dcount[1] == d0 && n < 500) begin
            n++;
            step();
        end
        check("fast_count", {vcount[1] - v0, dcount[1] - d0}, {32'd20, 32'd1});
        check("fast_values", vbad[1], 0);
        check("fast_gap2", gapbad[1], 0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
